// File: rtl/keccak_padder_multi_pkg.sv
// Shared constants, state encoding and helpers for the multi-message Keccak padder.
package keccak_pkg;

  localparam int RATE_SHA3_224 = 18;
  localparam int RATE_SHA3_256 = 17;
  localparam int RATE_SHA3_384 = 13;
  localparam int RATE_SHA3_512 = 9;
  localparam int RATE_SHAKE128 = 21;
  localparam int RATE_SHAKE256 = 17;

  localparam logic [7:0] DS_KECCAK = 8'h01;
  localparam logic [7:0] DS_SHA3   = 8'h06;
  localparam logic [7:0] DS_SHAKE  = 8'h1F;

  typedef enum logic [1:0] {
    IDLE,
    ABSORB,
    PAD,
    FULL
  } pad_state_e;

  // Zero or oversize rates fall back to the widest block the buffer holds.
  function automatic int clamp_rate(input int rate, input int max_rate);
    return (rate == 0 || rate > max_rate) ? max_rate : rate;
  endfunction

endpackage

// File: rtl/keccak_padder_multi_if.sv
// Byte-stream input and block output bundle between user, padder and permutation.
interface keccak_padder_multi_if
  import keccak_pkg::*;
#(
  parameter int MAX_RATE_WORDS = 21,
  parameter int CNT_W          = $clog2(MAX_RATE_WORDS + 1)
);

  logic [CNT_W-1:0]              rate_words;
  logic [7:0]                    dsbyte;
  logic [63:0]                   in;
  logic                          in_valid;
  logic                          is_last;
  logic [2:0]                    byte_num;
  logic                          in_ready;
  logic [64*MAX_RATE_WORDS-1:0]  out;
  logic                          out_valid;
  logic                          out_last;
  logic                          f_ack;

  modport master (
    output rate_words, dsbyte, in, in_valid, is_last, byte_num, f_ack,
    input  in_ready, out, out_valid, out_last
  );

  modport slave (
    input  rate_words, dsbyte, in, in_valid, is_last, byte_num, f_ack,
    output in_ready, out, out_valid, out_last
  );

endinterface

// File: rtl/keccak_padder_multi_pad_word.sv
// Builds one buffer word: truncates a final word, inserts the domain byte, sets the 0x80 end marker.
module keccak_pad_word
  import keccak_pkg::*;
(
  input  logic [63:0] in_i,
  input  logic [2:0]  byte_num_i,
  input  logic [7:0]  ds_i,
  input  logic        is_last_i,
  input  logic        is_final_slot_i,
  output logic [63:0] word_o
);

  always_comb begin
    word_o = '0;
    for (int b = 0; b < 8; b++) begin
      if (!is_last_i || b < int'(byte_num_i)) begin
        word_o[63-8*b -: 8] = in_i[63-8*b -: 8];
      end else if (b == int'(byte_num_i)) begin
        word_o[63-8*b -: 8] = ds_i;
      end
    end
    // OR rather than overwrite so a domain byte landing in byte 7 keeps its bits.
    if (is_final_slot_i) begin
      word_o[7:0] = word_o[7:0] | 8'h80;
    end
  end

endmodule

// File: rtl/keccak_padder_multi.sv
// Multi-message Keccak/SHA-3 padder: packs 64-bit words into rate-sized blocks with pad10*1.
//   state  | meaning
//   IDLE   | waiting for the first word of a message; rate/ds sampled here
//   ABSORB | accepting data words into the current block
//   PAD    | filling the rest of the final block with zero words
//   FULL   | block presented to the permutation until f_ack
module keccak_padder_multi
  import keccak_pkg::*;
#(
  parameter int MAX_RATE_WORDS = 21,
  parameter int CNT_W          = $clog2(MAX_RATE_WORDS + 1)
)(
  input  logic                  clk,
  input  logic                  reset,
  keccak_padder_multi_if.slave  bus
);

  pad_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  rate_q;
  logic [7:0]        ds_q;
  logic              last_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic [63:0]       blk_q [MAX_RATE_WORDS];

  logic              accept;
  logic [CNT_W-1:0]  rate_sel;
  logic [CNT_W-1:0]  rate_cur;
  logic [CNT_W-1:0]  slot;
  logic [CNT_W-1:0]  slot_nxt;
  logic              reach;
  logic [63:0]       pw_in;
  logic              pw_last;
  logic [7:0]        pw_ds;
  logic              pw_final;
  logic [63:0]       pad_word;
  logic [64*MAX_RATE_WORDS-1:0] out_flat;

  always_comb begin
    accept   = bus.in_valid & in_ready_q;
    rate_sel = CNT_W'(clamp_rate(int'(bus.rate_words), MAX_RATE_WORDS));
    rate_cur = (state_q == IDLE) ? rate_sel : rate_q;
    slot     = (state_q == IDLE) ? '0 : cnt_q;
    slot_nxt = slot + CNT_W'(1);
    reach    = (slot_nxt == rate_cur);
    pw_in    = (state_q == PAD) ? 64'd0 : bus.in;
    pw_last  = (state_q == PAD) ? 1'b0 : bus.is_last;
    pw_ds    = (state_q == IDLE) ? bus.dsbyte : ds_q;
    // The end marker belongs only to the message's last block.
    pw_final = (state_q == PAD) ? reach : (bus.is_last & reach);
  end

  keccak_pad_word u_pad_word (
    .in_i            (pw_in),
    .byte_num_i      (bus.byte_num),
    .ds_i            (pw_ds),
    .is_last_i       (pw_last),
    .is_final_slot_i (pw_final),
    .word_o          (pad_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rate_q      <= CNT_W'(MAX_RATE_WORDS);
      ds_q        <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int k = 0; k < MAX_RATE_WORDS; k++) blk_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE, ABSORB: begin
          if (accept) begin
            if (state_q == IDLE) begin
              rate_q <= rate_sel;
              ds_q   <= bus.dsbyte;
            end
            blk_q[slot] <= pad_word;
            cnt_q       <= slot_nxt;
            if (reach) begin
              state_q     <= FULL;
              last_q      <= bus.is_last;
              out_valid_q <= 1'b1;
              out_last_q  <= bus.is_last;
              in_ready_q  <= 1'b0;
            end else if (bus.is_last) begin
              state_q    <= PAD;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= ABSORB;
            end
          end
        end
        PAD: begin
          blk_q[slot] <= pad_word;
          cnt_q       <= slot_nxt;
          if (reach) begin
            state_q     <= FULL;
            last_q      <= 1'b1;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b1;
          end
        end
        FULL: begin
          if (bus.f_ack) begin
            for (int k = 0; k < MAX_RATE_WORDS; k++) blk_q[k] <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= last_q ? IDLE : ABSORB;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    out_flat = '0;
    for (int k = 0; k < MAX_RATE_WORDS; k++) begin
      out_flat[64*MAX_RATE_WORDS-1-64*k -: 64] = blk_q[k];
    end
  end

  assign bus.out       = out_flat;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;

endmodule
